// File: rtl/pattern_detector_7seg.sv
// Serial pattern detector with programmable pattern, overlap control and a
// BCD match counter shown on an active-high 7-segment display (dp = match).
module pattern_detector_7seg #(
    parameter int                 PAT_LEN  = 4,
    parameter logic [PAT_LEN-1:0] PAT_INIT = 4'b1011
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               overlap,
    input  logic               cfg_load,
    input  logic [PAT_LEN-1:0] cfg_pattern,
    input  logic               count_clr,
    output logic               match,
    output logic [3:0]         match_cnt,
    output logic               cnt_wrap,
    output logic [7:0]         seg
);

    localparam int FW = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(PAT_LEN);

    logic [PAT_LEN-1:0] pattern;
    logic [PAT_LEN-1:0] history;
    logic [FW-1:0]      fill;

    logic [PAT_LEN-1:0] hist_next;
    logic [FW-1:0]      fill_next;
    logic               hit;
    logic [3:0]         cnt_next;
    logic               wrap_next;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    seg_digit = 7'h3F;
            4'd1:    seg_digit = 7'h06;
            4'd2:    seg_digit = 7'h5B;
            4'd3:    seg_digit = 7'h4F;
            4'd4:    seg_digit = 7'h66;
            4'd5:    seg_digit = 7'h6D;
            4'd6:    seg_digit = 7'h7D;
            4'd7:    seg_digit = 7'h07;
            4'd8:    seg_digit = 7'h7F;
            4'd9:    seg_digit = 7'h6F;
            default: seg_digit = 7'h00;
        endcase
    endfunction

    // A bit arriving alongside cfg_load is discarded, so it can never hit.
    always_comb begin
        hist_next = {history[PAT_LEN-2:0], in_bit};
        fill_next = (fill == FILL_FULL) ? fill : fill + FW'(1);
        hit       = in_valid && !cfg_load && (fill_next == FILL_FULL) &&
                    (hist_next == pattern);
        cnt_next  = match_cnt;
        wrap_next = cnt_wrap;
        if (count_clr) begin
            cnt_next  = 4'd0;
            wrap_next = 1'b0;
        end else if (hit) begin
            if (match_cnt == 4'd9) begin
                cnt_next  = 4'd0;
                wrap_next = 1'b1;
            end else begin
                cnt_next = match_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern   <= PAT_INIT;
            history   <= '0;
            fill      <= '0;
            match     <= 1'b0;
            match_cnt <= 4'd0;
            cnt_wrap  <= 1'b0;
            seg       <= 8'h3F;
        end else begin
            match     <= hit;
            match_cnt <= cnt_next;
            cnt_wrap  <= wrap_next;
            seg       <= {hit, seg_digit(cnt_next)};
            if (cfg_load) begin
                pattern <= cfg_pattern;
                history <= '0;
                fill    <= '0;
            end else if (in_valid) begin
                history <= hist_next;
                // Non-overlapping mode keeps history but demands a full refill.
                fill    <= (hit && !overlap) ? '0 : fill_next;
            end
        end
    end

endmodule

// File: tb/tb_pattern_detector_7seg.sv
// Directed, table-driven bench for pattern_detector_7seg plus a hand-written
// ten-match wrap sequence.
module tb_pattern_detector_7seg;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       overlap = 1'b1;
    logic       cfg_load = 1'b0;
    logic [3:0] cfg_pattern = 4'd0;
    logic       count_clr = 1'b0;
    logic       match;
    logic [3:0] match_cnt;
    logic       cnt_wrap;
    logic [7:0] seg;

    int checks = 0;
    int errors = 0;

    pattern_detector_7seg #(.PAT_LEN(4), .PAT_INIT(4'b1011)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .overlap(overlap), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .count_clr(count_clr), .match(match), .match_cnt(match_cnt),
        .cnt_wrap(cnt_wrap), .seg(seg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r, v, b, o, l;
        logic [3:0] p;
        logic       c;
        logic       m;
        logic [3:0] cnt;
        logic       w;
        logic [7:0] sg;
    } vec_t;

    vec_t tbl[$];
    logic [6:0] dig[10];

    function automatic void add(input logic r, v, b, o, l, input logic [3:0] p,
                                input logic c, m, input logic [3:0] cnt,
                                input logic w, input logic [7:0] sg);
        vec_t t;
        t.r = r; t.v = v; t.b = b; t.o = o; t.l = l; t.p = p; t.c = c;
        t.m = m; t.cnt = cnt; t.w = w; t.sg = sg;
        tbl.push_back(t);
    endfunction

    task automatic drive(input logic r, v, b, o, l, input logic [3:0] p, input logic c);
        @(negedge clk);
        rst = r; in_valid = v; in_bit = b; overlap = o;
        cfg_load = l; cfg_pattern = p; count_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic m, input logic [3:0] cnt,
                              input logic w, input logic [7:0] sg);
        check({tag, ".match"}, {7'd0, match}, {7'd0, m});
        check({tag, ".cnt"}, {4'd0, match_cnt}, {4'd0, cnt});
        check({tag, ".wrap"}, {7'd0, cnt_wrap}, {7'd0, w});
        check({tag, ".seg"}, seg, sg);
    endtask

    task automatic bit_in(input logic b);
        drive(1'b0, 1'b1, b, 1'b1, 1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        dig = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

        //   r v b o l  p       c  m cnt w  seg
        // reset, then 1,0,1,1 with a gap
        add(1,0,0,1,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,1,1,1,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,1,0,1,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,0,1,1,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,1,1,1,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,1,1,1,0,4'h0,   0, 1,1,0,8'h86);
        add(0,0,0,1,0,4'h0,   0, 0,1,0,8'h06);
        // reset wins over cfg_load/count_clr/valid; pattern stays 1011
        add(1,1,1,1,1,4'h0,   1, 0,0,0,8'h3F);
        add(0,1,1,1,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,1,0,1,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,1,1,1,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,1,1,1,0,4'h0,   0, 1,1,0,8'h86);
        // overlap=1: 1011011 -> two matches
        add(1,0,0,1,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,1,1,1,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,1,0,1,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,1,1,1,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,1,1,1,0,4'h0,   0, 1,1,0,8'h86);
        add(0,1,0,1,0,4'h0,   0, 0,1,0,8'h06);
        add(0,1,1,1,0,4'h0,   0, 0,1,0,8'h06);
        add(0,1,1,1,0,4'h0,   0, 1,2,0,8'hDB);
        // overlap=0: same stream -> one match
        add(1,0,0,0,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,1,1,0,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,1,0,0,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,1,1,0,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,1,1,0,0,4'h0,   0, 1,1,0,8'h86);
        add(0,1,0,0,0,4'h0,   0, 0,1,0,8'h06);
        add(0,1,1,0,0,4'h0,   0, 0,1,0,8'h06);
        add(0,1,1,0,0,4'h0,   0, 0,1,0,8'h06);
        // count_clr on a match cycle: pulse but count stays 0
        add(1,0,0,1,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,1,1,1,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,1,0,1,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,1,1,1,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,1,1,1,0,4'h0,   1, 1,0,0,8'hBF);
        add(0,0,0,1,0,4'h0,   0, 0,0,0,8'h3F);
        // cfg_load 0110 with a valid bit, then 0110 matches, 1011 does not
        add(1,0,0,1,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,1,0,1,1,4'b0110,0, 0,0,0,8'h3F);
        add(0,1,0,1,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,1,1,1,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,1,1,1,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,1,0,1,0,4'h0,   0, 1,1,0,8'h86);
        add(0,1,1,1,0,4'h0,   0, 0,1,0,8'h06);
        add(0,1,0,1,0,4'h0,   0, 0,1,0,8'h06);
        add(0,1,1,1,0,4'h0,   0, 0,1,0,8'h06);
        add(0,1,1,1,0,4'h0,   0, 0,1,0,8'h06);
        // cfg_load keeps the count and drops a completing bit
        add(0,1,1,1,1,4'b1011,0, 0,1,0,8'h06);
        add(0,1,0,1,0,4'h0,   0, 0,1,0,8'h06);
        add(0,1,1,1,0,4'h0,   0, 0,1,0,8'h06);
        add(0,1,1,1,1,4'b1011,0, 0,1,0,8'h06);
        add(0,1,1,1,0,4'h0,   0, 0,1,0,8'h06);
        // reset mid-sequence discards history
        add(1,0,0,1,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,1,1,1,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,1,0,1,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,1,1,1,0,4'h0,   0, 0,0,0,8'h3F);
        add(1,0,0,1,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,1,1,1,0,4'h0,   0, 0,0,0,8'h3F);
        // gaps between 1,0,1,1 still detect
        add(0,1,1,1,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,0,1,1,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,1,0,1,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,0,1,1,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,0,0,1,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,1,1,1,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,0,0,1,0,4'h0,   0, 0,0,0,8'h3F);
        add(0,1,1,1,0,4'h0,   0, 1,1,0,8'h86);
        add(0,0,0,1,0,4'h0,   0, 0,1,0,8'h06);

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].b, tbl[i].o, tbl[i].l, tbl[i].p, tbl[i].c);
            expect_out($sformatf("vec%0d", i), tbl[i].m, tbl[i].cnt, tbl[i].w, tbl[i].sg);
        end

        // Ten overlapping matches: 1011 then (011) x9
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        expect_out("wrap.rst", 1'b0, 4'd0, 1'b0, 8'h3F);
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        expect_out("wrap.pre", 1'b0, 4'd0, 1'b0, 8'h3F);
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) begin
                bit_in(1'b0);
                bit_in(1'b1);
                check($sformatf("wrap.gap%0d", k), {7'd0, match}, 8'd0);
            end
            bit_in(1'b1);
            expect_out($sformatf("wrap.m%0d", k), 1'b1, 4'(k % 10), k == 10,
                       {1'b1, dig[k % 10]});
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        expect_out("wrap.idle", 1'b0, 4'd0, 1'b1, 8'h3F);
        bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
        expect_out("wrap.sticky", 1'b1, 4'd1, 1'b1, 8'h86);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1);
        expect_out("wrap.clr", 1'b0, 4'd0, 1'b0, 8'h3F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pattern_detector_7seg.md
PATTERN_DETECTOR_7SEG -- requirements
Module: pattern_detector_7seg

Interface
REQ-001 The block SHALL have parameter PAT_LEN, default 4, giving the pattern length in bits (legal 2..8).
REQ-002 The block SHALL have parameter PAT_INIT, default 4'b1011, the PAT_LEN-bit pattern loaded at reset; the MSB is the oldest bit.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  qualifies in_bit; no state advances when low.
REQ-006 in_bit  input  1  serial data bit.
REQ-007 overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled per valid bit.
REQ-008 cfg_load  input  1  loads cfg_pattern into the pattern register.
REQ-009 cfg_pattern  input  PAT_LEN  new pattern, MSB oldest.
REQ-010 count_clr  input  1  clears match_cnt and cnt_wrap.
REQ-011 match  output  1  one-cycle pulse per detected pattern.
REQ-012 match_cnt  output  4  BCD match count, 0..9.
REQ-013 cnt_wrap  output  1  sticky; set when match_cnt wraps 9->0.
REQ-014 seg  output  8  7-segment display, active-high; seg[6:0]={g,f,e,d,c,b,a}, seg[7]=dp.

Function
REQ-015 The block SHALL keep a PAT_LEN-bit history shift register (new bit enters the LSB) and a fill counter saturating at PAT_LEN.
REQ-016 On a cycle with in_valid=1, history SHALL shift in in_bit and fill SHALL increment (saturating).
REQ-017 A match SHALL be detected when, after the shift, fill==PAT_LEN and history equals the pattern register.
REQ-018 match SHALL be registered: it is 1 for exactly the cycle following the edge that samples the completing bit, else 0.
REQ-019 With overlap=1, history and fill SHALL be kept after a match, so trailing bits may start a new match.
REQ-020 With overlap=0, fill SHALL be cleared to 0 on the match edge; the next match needs PAT_LEN fresh valid bits.
REQ-021 On each match, match_cnt SHALL increment by one on the same edge that raises match; 9 SHALL wrap to 0 and set cnt_wrap.
REQ-022 seg[6:0] SHALL be the standard digit of match_cnt (0=7'h3F,1=7'h06,2=7'h5B,3=7'h4F,4=7'h66,5=7'h6D,6=7'h7D,7=7'h07,8=7'h7F,9=7'h6F); seg[7] SHALL equal match.
REQ-023 seg SHALL be registered and SHALL reflect the updated match_cnt in the same cycle as match.
REQ-024 cfg_load=1 SHALL load cfg_pattern, clear history and fill, and drop any same-cycle valid bit (no match from it); match_cnt is kept.
REQ-025 count_clr=1 SHALL set match_cnt=0 and cnt_wrap=0; if a match occurs the same cycle, match still pulses but the count SHALL stay 0.
REQ-026 in_valid=0 cycles SHALL NOT break a partial sequence; detection spans gaps.

Reset
REQ-027 While rst=1 on a clock edge: pattern=PAT_INIT, history=0, fill=0, match=0, match_cnt=0, cnt_wrap=0, seg=8'h3F.
REQ-028 rst SHALL take priority over cfg_load, count_clr and in_valid; reset mid-sequence SHALL discard partial history.

Verification
REQ-029 Reset, overlap=1, valid bits 1,0,1,1 -> match=1 one cycle after 4th bit, match_cnt=1, seg=8'h86.
REQ-030 overlap=1, bits 1,0,1,1,0,1,1 -> two match pulses (after bits 4 and 7), match_cnt=2; same stream with overlap=0 -> one pulse, match_cnt=1.
REQ-031 Ten matches from reset -> match_cnt goes 1..9 then 0, cnt_wrap=1, seg=8'h3F on 10th match cycle plus dp=1 (8'hBF); then count_clr -> cnt_wrap=0.
REQ-032 cfg_load with cfg_pattern=4'b0110 while in_valid=1 -> no match that cycle; following bits 0,1,1,0 -> match; bits 1,0,1,1 -> no match.
REQ-033 Bits 1,0,1 then rst=1 one cycle, then bit 1 -> no match, match_cnt=0, seg=8'h3F; in_valid gaps between 1,0,1,1 -> still one match.
